oam_dma_ctrl: RTL and testbench
===============================

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have ports: b_rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: cpu_addr_out  in  16  CPU address; cpu_data_out  in  8  CPU write data; ren / wen  in  1  CPU read/write strobes.
REQ-004 SHALL have ports: mem_data_in  in  8  memory read data, combinational with bus_addr (same-cycle valid).
REQ-005 SHALL have ports: bus_addr  out  16; bus_data  out  8; bus_ren  out  1; bus_wen  out  1 -- arbitrated memory-side bus.
REQ-006 SHALL have ports: rdy  out  1  CPU ready (0 = CPU stalled); dma_busy  out  1; dma_done  out  1  one-cycle pulse.
REQ-007 SHALL have parameters: DMA_REG, default 16'h4014, trigger address; OAM_DATA, default 16'h2004, DMA write target.
REQ-008 Clock port SHALL be named clk; reset SHALL be b_rst, asynchronous, active-low.

Function
REQ-009 States SHALL be IDLE, HALT, ALIGN, READ, WRITE.
REQ-010 A free-running parity flop SHALL toggle every cycle; value 0 after reset.
REQ-011 IDLE: bus_addr/bus_data/bus_ren/bus_wen SHALL equal cpu_addr_out/cpu_data_out/ren/wen combinationally; rdy=1.
REQ-012 IDLE with wen=1 and cpu_addr_out==DMA_REG SHALL forward that write, latch page=cpu_data_out, clear count, and go to HALT next cycle.
REQ-013 In every state other than IDLE, rdy SHALL be 0, dma_busy SHALL be 1, and CPU strobes SHALL be ignored (not forwarded).
REQ-014 HALT (1 cycle): bus_ren=bus_wen=0. Next state SHALL be READ if parity==1, else ALIGN.
REQ-015 ALIGN (1 cycle): bus idle; next state READ. READ SHALL therefore always begin on a parity-0 cycle.
REQ-016 READ: bus_addr={page,count}, bus_ren=1, bus_wen=0. mem_data_in SHALL be captured into an 8-bit latch at cycle end. Next state WRITE.
REQ-017 WRITE: bus_addr=OAM_DATA, bus_data=latch, bus_wen=1, bus_ren=0. count SHALL increment (8-bit).
REQ-018 In WRITE, if count==8'hFF, next state SHALL be IDLE and dma_done SHALL pulse 1 in the following (first IDLE) cycle; otherwise the next state is READ.
REQ-019 A transfer SHALL be exactly 256 READ/WRITE pairs. Total stall (rdy=0) is 513 cycles when HALT has parity 1, 514 otherwise.
REQ-020 Source address SHALL NOT carry into page: {page,8'hFF} is the last read, with no wrap to page+1. Page 8'hFF is legal.
REQ-021 A DMA_REG write SHALL NOT trigger when ren=1 only. Simultaneous ren and wen in IDLE SHALL be forwarded as-is; the trigger depends on wen alone.
REQ-022 The CPU cannot issue a write while rdy=0. Any DMA_REG access outside IDLE SHALL have no effect.
REQ-023 When not active, bus_data SHALL be 8'h00 in HALT, ALIGN, and READ.

Reset
REQ-024 b_rst=0 SHALL immediately force: state=IDLE, count=0, page=0, latch=0, parity=0, dma_done=0, rdy=1, dma_busy=0.
REQ-025 Reset asserted mid-transfer SHALL abort the transfer with no further bus_wen. After release, IDLE passthrough resumes on the next cycle.

Verification
REQ-026 Reset, then write 8'h02 to 16'h4014 with HALT on a parity-1 cycle -> rdy low 513 cycles; reads 16'h0200..16'h02FF in order; 256 writes to 16'h2004 with the matching data; one dma_done pulse.
REQ-027 Same trigger with HALT on a parity-0 cycle -> ALIGN visited once, rdy low 514 cycles, data identical.
REQ-028 Page 8'hFF, memory preloaded with byte i at 16'hFF00+i -> last read address 16'hFFFF; OAM write sequence 0..255; no access to 16'h0000.
REQ-029 Read (ren=1, wen=0) of 16'h4014 and write to 16'h4015 -> no stall, rdy stays 1, accesses passed through unchanged.
REQ-030 Assert b_rst at the 100th WRITE -> rdy=1 and dma_busy=0 immediately, no further bus_wen to 16'h2004; a new trigger after reset runs a full 256-byte transfer.
REQ-031 Strobe CPU wen on 16'h4014 during an active DMA -> page unchanged, transfer length unchanged, nothing forwarded.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: arbitrates a single memory-side bus between the CPU and
// a 256-byte page copy into the OAM data port. A CPU write of a page number to
// DMA_REG stalls the CPU, optionally burns one alignment cycle so every read
// lands on an even (parity-0) cycle, then runs 256 read/write pairs.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_DATA = 16'h2004
) (
    input  logic        clk,
    input  logic        b_rst,
    input  logic [15:0] cpu_addr_out,
    input  logic [7:0]  cpu_data_out,
    input  logic        ren,
    input  logic        wen,
    input  logic [7:0]  mem_data_in,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data,
    output logic        bus_ren,
    output logic        bus_wen,
    output logic        rdy,
    output logic        dma_busy,
    output logic        dma_done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HALT  = 3'd1;
    localparam logic [2:0] ALIGN = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;

    logic [2:0] state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] page_q,  page_d;
    logic [7:0] latch_q, latch_d;
    logic       parity_q, parity_d;
    logic       done_q,  done_d;

    // Next-state logic: trigger detection, alignment choice and byte sequencing.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        page_d   = page_q;
        latch_d  = latch_q;
        parity_d = ~parity_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wen && (cpu_addr_out == DMA_REG)) begin
                    page_d  = cpu_data_out;
                    count_d = 8'd0;
                    state_d = HALT;
                end
            end
            HALT:  state_d = parity_q ? READ : ALIGN;
            ALIGN: state_d = READ;
            READ: begin
                latch_d = mem_data_in;
                state_d = WRITE;
            end
            WRITE: begin
                count_d = count_q + 8'd1;
                if (count_q == 8'hFF) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any transfer in flight at once.
    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            state_q  <= IDLE;
            count_q  <= 8'd0;
            page_q   <= 8'd0;
            latch_q  <= 8'd0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            page_q   <= page_d;
            latch_q  <= latch_d;
            parity_q <= parity_d;
            done_q   <= done_d;
        end
    end

    // Bus mux: CPU passthrough in IDLE, DMA owns the bus in every other state.
    always_comb begin
        bus_addr = cpu_addr_out;
        bus_data = cpu_data_out;
        bus_ren  = ren;
        bus_wen  = wen;
        case (state_q)
            IDLE: ;
            READ: begin
                bus_addr = {page_q, count_q};
                bus_data = 8'h00;
                bus_ren  = 1'b1;
                bus_wen  = 1'b0;
            end
            WRITE: begin
                bus_addr = OAM_DATA;
                bus_data = latch_q;
                bus_ren  = 1'b0;
                bus_wen  = 1'b1;
            end
            default: begin
                bus_addr = {page_q, count_q};
                bus_data = 8'h00;
                bus_ren  = 1'b0;
                bus_wen  = 1'b0;
            end
        endcase
    end

    assign dma_busy = (state_q != IDLE);
    assign rdy      = ~dma_busy;
    assign dma_done = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: passthrough, full transfers with both
// alignment cases, page 8'hFF, CPU strobes during DMA, and reset mid-transfer.
module tb_oam_dma_ctrl;

    logic        clk;
    logic        b_rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        c_ren;
    logic        c_wen;
    logic [7:0]  mem_data_in;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data;
    logic        bus_ren;
    logic        bus_wen;
    logic        rdy;
    logic        dma_busy;
    logic        dma_done;

    int n_cmp = 0;
    int n_err = 0;
    logic tb_par;

    oam_dma_ctrl #(.DMA_REG(16'h4014), .OAM_DATA(16'h2004)) dut (
        .clk(clk), .b_rst(b_rst),
        .cpu_addr_out(cpu_addr), .cpu_data_out(cpu_data), .ren(c_ren), .wen(c_wen),
        .mem_data_in(mem_data_in),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_ren(bus_ren), .bus_wen(bus_wen),
        .rdy(rdy), .dma_busy(dma_busy), .dma_done(dma_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: page FF holds byte i at FF00+i, other pages a scrambled pattern.
    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        if (a[15:8] == 8'hFF) return a[7:0];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction
    assign mem_data_in = mem_fn(bus_addr);

    // Reference parity: toggles every cycle from reset.
    always @(posedge clk or negedge b_rst) begin
        if (!b_rst) tb_par <= 1'b0;
        else        tb_par <= ~tb_par;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return {3'b000, bus_addr, bus_data, bus_ren, bus_wen, rdy, dma_busy, dma_done};
    endfunction

    function automatic logic [31:0] mk(input logic [15:0] a, input logic [7:0] d,
                                       input logic r, input logic w, input logic rd,
                                       input logic bz, input logic dn);
        return {3'b000, a, d, r, w, rd, bz, dn};
    endfunction

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w);
        cpu_addr = a; cpu_data = d; c_ren = r; c_wen = w;
    endtask

    // Issue the trigger so the following HALT cycle has parity hp.
    task automatic trigger(input logic [7:0] pg, input logic hp);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            drive(16'h0000, 8'h00, 1'b0, 1'b0);
            if (tb_par == ~hp) break;
        end
        drive(16'h4014, pg, 1'b0, 1'b1);
        #1;
        chk("trigger_fwd", obs_vec(), mk(16'h4014, pg, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    endtask

    task automatic run_dma(input logic [7:0] pg, input logic hp, input logic strobe, input int abort_at);
        int ncyc;
        int pre;
        int k;
        int i;
        int stall;
        logic [15:0] last_rd;
        logic [31:0] exp;
        logic [31:0] msk;
        ncyc = hp ? 513 : 514;
        pre = hp ? 1 : 2;
        stall = 0;
        last_rd = 16'h0000;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (strobe && c >= 1 && c < 300)
                drive(16'h4014, 8'h55, c[0], 1'b1);
            else
                drive(16'h0000, 8'h00, 1'b0, 1'b0);
            #1;
            msk = 32'hFFFF_FFFF;
            k = c - pre;
            i = k >>> 1;
            if (c < pre) begin
                exp = mk(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                msk = {3'b000, 16'h0000, 13'h1FFF};
            end else if (k[0] == 1'b0) begin
                exp = mk({pg, i[7:0]}, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
                if (bus_ren) last_rd = bus_addr;
            end else begin
                exp = mk(16'h2004, mem_fn({pg, i[7:0]}), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            end
            if (!rdy) stall++;
            chk($sformatf("dma_cyc%0d_pg%02h", c, pg), obs_vec() & msk, exp & msk);
            if (abort_at >= 0 && c >= pre && k[0] == 1'b1 && i == abort_at) begin
                #1 b_rst = 1'b0;
                #1;
                chk("abort_immediate", {28'h0, bus_wen, rdy, dma_busy, dma_done}, 32'h4);
                for (int n = 0; n < 3; n++) begin
                    @(negedge clk);
                    #1;
                    chk("abort_no_wen", {31'h0, bus_wen}, 32'h0);
                end
                @(negedge clk);
                b_rst = 1'b1;
                drive(16'h4015, 8'h3C, 1'b0, 1'b1);
                #1;
                chk("post_abort_pass", obs_vec(), mk(16'h4015, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
                @(negedge clk);
                drive(16'h0000, 8'h00, 1'b0, 1'b0);
                #1;
                chk("post_abort_idle", {30'h0, rdy, dma_busy}, 32'h2);
                return;
            end
        end
        @(negedge clk);
        drive(16'h0123, 8'h99, 1'b1, 1'b0);
        #1;
        if (!rdy) stall++;
        chk("done_pulse", obs_vec(), mk(16'h0123, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
        chk("stall_len", stall, ncyc);
        chk("last_read", {16'h0, last_rd}, {16'h0, pg, 8'hFF});
        @(negedge clk);
        drive(16'h0000, 8'h00, 1'b0, 1'b0);
        #1;
        chk("done_clear", {29'h0, rdy, dma_busy, dma_done}, 32'h4);
    endtask

    initial begin
        b_rst = 1'b0;
        drive(16'h1234, 8'h5A, 1'b1, 1'b0);
        #12;
        chk("reset_state", obs_vec(), mk(16'h1234, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        b_rst = 1'b1;

        // CPU read of the trigger register and write to its neighbour pass straight through.
        @(negedge clk);
        drive(16'h4014, 8'h07, 1'b1, 1'b0);
        #1;
        chk("read_4014_pass", obs_vec(), mk(16'h4014, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        drive(16'h4015, 8'h77, 1'b0, 1'b1);
        #1;
        chk("write_4015_pass", obs_vec(), mk(16'h4015, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            drive(16'h0000, 8'h00, 1'b0, 1'b0);
            #1;
            chk("no_stall", {30'h0, rdy, dma_busy}, 32'h2);
        end

        trigger(8'h02, 1'b1);
        run_dma(8'h02, 1'b1, 1'b0, -1);

        trigger(8'h02, 1'b0);
        run_dma(8'h02, 1'b0, 1'b1, -1);

        trigger(8'hFF, 1'b1);
        run_dma(8'hFF, 1'b1, 1'b0, -1);

        trigger(8'h10, 1'b0);
        run_dma(8'h10, 1'b0, 1'b0, 99);

        trigger(8'h03, 1'b1);
        run_dma(8'h03, 1'b1, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
